// File: rtl/ahb_arb_core_if.sv
// ahb_arb_core_if: arbiter bundle; master drives hbusreq/hlock/hgrant/hready/htrans/hburst, slave (core) returns grant/mastlock/transfin
interface ahb_arb_core_if;
  logic [4:0] hbusreq;
  logic [4:0] hlock;
  logic [4:0] hgrant;
  logic       hready;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic [4:0] grant;
  logic       mastlock;
  logic       transfin;
  modport master (
    output hbusreq, hlock, hgrant, hready, htrans, hburst,
    input  grant, mastlock, transfin
  );
  modport slave (
    input  hbusreq, hlock, hgrant, hready, htrans, hburst,
    output grant, mastlock, transfin
  );
endinterface

// File: rtl/ahb_arb_core.sv
// ahb_arb_core: 5-master AHB round-robin arbitration with default master, lock hold and burst beat tracking; ports hclk, hreset, bus (slave: requests/owner/transfer in, grant/mastlock/transfin out)
module ahb_arb_core #(
  parameter int DEF_MST = 0
) (
  input logic           hclk,
  input logic           hreset,
  ahb_arb_core_if.slave bus
);
  logic [2:0] r_ptr;
  logic [4:0] r_cnt;
  logic [4:0] w_len;
  logic [4:0] w_cnt_next;
  logic [2:0] w_cur;
  logic [2:0] w_win;
  logic [2:0] w_sel;
  logic       w_hold;
  always_comb begin
    w_len = bus.hburst < 3'd2 ? 5'd1 : bus.hburst < 3'd4 ? 5'd4 : bus.hburst < 3'd6 ? 5'd8 : 5'd16;
    w_cnt_next = !bus.hready ? r_cnt :
                 bus.htrans == 2'b10 ? w_len - 5'd1 :
                 bus.htrans == 2'b11 ? (r_cnt != 5'd0 ? r_cnt - 5'd1 : 5'd0) :
                 bus.htrans == 2'b01 ? r_cnt : 5'd0;
    w_cur = 3'd0;
    for (int i = 0; i < 5; i++) if (bus.hgrant[i]) w_cur = 3'(i);
    w_hold = |bus.hgrant & bus.hlock[w_cur] & bus.hbusreq[w_cur];
    w_win = 3'(DEF_MST);
    for (int k = 5; k >= 1; k--) if (bus.hbusreq[3'((int'(r_ptr) + k) % 5)]) w_win = 3'((int'(r_ptr) + k) % 5);
    w_sel = w_hold ? w_cur : |bus.hbusreq ? w_win : 3'(DEF_MST);
  end
  assign bus.grant    = 5'd1 << w_sel;
  assign bus.mastlock = bus.hlock[w_sel];
  assign bus.transfin = w_cnt_next == 5'd0;
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_ptr <= 3'd4;
      r_cnt <= 5'd0;
    end else begin
      r_cnt <= w_cnt_next;
      if (bus.hready & bus.transfin & |bus.hbusreq) r_ptr <= w_sel;
    end
  end
endmodule
